trng_conditioner: RTL



---
 rtl/trng_pkg.sv | 14 +
 rtl/trng_conditioner_if.sv | 25 ++
 rtl/trng_word_fifo.sv | 50 +++++
 rtl/trng_conditioner.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// Shared constants for the TRNG entropy conditioner: adaptive-proportion test window and limits,
// plus the FIFO pointer-width helper.
package trng_pkg;

    localparam int unsigned APT_WINDOW = 64;
    localparam int unsigned APT_HI     = 56;
    localparam int unsigned APT_LO     = 8;

    // One extra wrap bit so full and empty are distinguishable.
    function automatic int unsigned fifo_ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/trng_conditioner_if.sv
// Raw-sample input, SoC word handshake and health signalling of the TRNG conditioner.
// The master modport is the SoC/source side; the slave modport is the conditioner.
interface trng_conditioner_if #(
    parameter int unsigned TRNG_WIDTH = 8
) ();

    logic                  raw_bit;
    logic                  raw_valid;
    logic                  trng_req;
    logic [TRNG_WIDTH-1:0] trng_word;
    logic                  trng_valid;
    logic                  health_fail;
    logic                  clear_fail;

    modport master (
        output raw_bit, raw_valid, trng_req, clear_fail,
        input  trng_word, trng_valid, health_fail
    );

    modport slave (
        input  raw_bit, raw_valid, trng_req, clear_fail,
        output trng_word, trng_valid, health_fail
    );

endinterface

// File: rtl/trng_word_fifo.sv
// Synchronous word FIFO with flush. A push into a full FIFO is dropped unless a pop
// happens in the same cycle.
module trng_word_fifo
    import trng_pkg::*;
#(
    parameter int unsigned TRNG_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  push,
    input  logic [TRNG_WIDTH-1:0] push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic [TRNG_WIDTH-1:0] head,
    output logic                  empty,
    output logic                  full
);

    localparam int unsigned PW = fifo_ptr_width(FIFO_DEPTH);
    localparam int unsigned AW = PW - 1;

    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [TRNG_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                  do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/trng_conditioner.sv
// Entropy front-end: von Neumann debiasing, repetition-count health test, LSB-first word packing,
// word FIFO and registered SoC handshake. Define TRNG_APT_EN to add the adaptive-proportion test.
module trng_conditioner
    import trng_pkg::*;
#(
    parameter int unsigned TRNG_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RCT_CUTOFF = 32
) (
    input logic               clk,
    input logic               resetn,
    trng_conditioner_if.slave bus
);

    localparam int unsigned CW  = $clog2(RCT_CUTOFF + 1);
    localparam int unsigned PCW = $clog2(TRNG_WIDTH + 1);

    logic                  prev_bit_q;
    logic [CW-1:0]         rct_cnt_q, rct_cnt_d;
    logic                  rct_fire, apt_fire, fail_event;
    logic                  health_fail_q, health_fail_d;
    logic                  pair_full_q, pair_full_d, pair_bit_q, pair_bit_d;
    logic [TRNG_WIDTH-1:0] pack_q, pack_d, shifted, push_word;
    logic [PCW-1:0]        pack_cnt_q, pack_cnt_d;
    logic                  push, pop, fifo_empty, fifo_full;
    logic [TRNG_WIDTH-1:0] fifo_head, trng_word_q;
    logic                  trng_valid_q;

    // A zero count means no previous sample since reset/clear, so the next sample starts a run.
    always_comb begin
        rct_cnt_d = rct_cnt_q;
        if (bus.raw_valid) begin
            if (rct_cnt_q == '0 || bus.raw_bit != prev_bit_q) rct_cnt_d = CW'(1);
            else if (rct_cnt_q != CW'(RCT_CUTOFF))            rct_cnt_d = rct_cnt_q + CW'(1);
        end
    end

    assign rct_fire = bus.raw_valid && (rct_cnt_d == CW'(RCT_CUTOFF));

`ifdef TRNG_APT_EN
    localparam int unsigned AWW = $clog2(APT_WINDOW);
    localparam int unsigned AOW = AWW + 1;

    logic [AWW-1:0] apt_win_q;
    logic [AOW-1:0] apt_ones_q, apt_ones_next;

    assign apt_ones_next = apt_ones_q + {{AWW{1'b0}}, bus.raw_bit};
    assign apt_fire      = bus.raw_valid && (apt_win_q == AWW'(APT_WINDOW - 1)) &&
                           (apt_ones_next >= AOW'(APT_HI) || apt_ones_next <= AOW'(APT_LO));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            apt_win_q  <= '0;
            apt_ones_q <= '0;
        end else if (bus.clear_fail && !fail_event) begin
            apt_win_q  <= '0;
            apt_ones_q <= '0;
        end else if (bus.raw_valid) begin
            if (apt_win_q == AWW'(APT_WINDOW - 1)) begin
                apt_win_q  <= '0;
                apt_ones_q <= '0;
            end else begin
                apt_win_q  <= apt_win_q + AWW'(1);
                apt_ones_q <= apt_ones_next;
            end
        end
    end
`else
    assign apt_fire = 1'b0;
`endif

    assign fail_event = rct_fire || apt_fire;
    assign shifted    = {pair_bit_q, pack_q[TRNG_WIDTH-1:1]};

    always_comb begin
        pair_full_d   = pair_full_q;
        pair_bit_d    = pair_bit_q;
        pack_d        = pack_q;
        pack_cnt_d    = pack_cnt_q;
        push          = 1'b0;
        push_word     = shifted;
        health_fail_d = health_fail_q;
        if (fail_event) health_fail_d = 1'b1;
        else if (bus.clear_fail) health_fail_d = 1'b0;

        if (fail_event || bus.clear_fail) begin
            pair_full_d = 1'b0;
            pack_d      = '0;
            pack_cnt_d  = '0;
        end else if (bus.raw_valid && !health_fail_q) begin
            if (!pair_full_q) begin
                pair_full_d = 1'b1;
                pair_bit_d  = bus.raw_bit;
            end else begin
                pair_full_d = 1'b0;
                if (pair_bit_q != bus.raw_bit) begin
                    if (pack_cnt_q == PCW'(TRNG_WIDTH - 1)) begin
                        push       = 1'b1;
                        pack_d     = '0;
                        pack_cnt_d = '0;
                    end else begin
                        pack_d     = shifted;
                        pack_cnt_d = pack_cnt_q + PCW'(1);
                    end
                end
            end
        end
    end

    // No pop on the failure cycle: the FIFO is being flushed.
    assign pop = bus.trng_req && !fifo_empty && !health_fail_q && !fail_event;

    trng_word_fifo #(
        .TRNG_WIDTH(TRNG_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (push),
        .push_data(push_word),
        .pop      (pop),
        .flush    (fail_event),
        .head     (fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_bit_q    <= 1'b0;
            rct_cnt_q     <= '0;
            health_fail_q <= 1'b0;
            pair_full_q   <= 1'b0;
            pair_bit_q    <= 1'b0;
            pack_q        <= '0;
            pack_cnt_q    <= '0;
            trng_valid_q  <= 1'b0;
            trng_word_q   <= '0;
        end else begin
            if (bus.raw_valid) prev_bit_q <= bus.raw_bit;
            rct_cnt_q     <= (bus.clear_fail && !fail_event) ? '0 : rct_cnt_d;
            health_fail_q <= health_fail_d;
            pair_full_q   <= pair_full_d;
            pair_bit_q    <= pair_bit_d;
            pack_q        <= pack_d;
            pack_cnt_q    <= pack_cnt_d;
            trng_valid_q  <= pop;
            if (pop) trng_word_q <= fifo_head;
        end
    end

    assign bus.trng_word   = trng_word_q;
    assign bus.trng_valid  = trng_valid_q;
    assign bus.health_fail = health_fail_q;

endmodule
